// File: rtl/mips150_mmio_pkg.sv
// Shared address-map constants for the MIPS150 memory-map decoder and I/O block.
package mips150_mmio_pkg;

    localparam logic [3:0] REGION_DMEM = 4'h1;
    localparam logic [3:0] REGION_IMEM = 4'h2;
    localparam logic [3:0] REGION_BOTH = 4'h3;
    localparam logic [3:0] REGION_IO   = 4'h8;

    localparam logic [7:0] OFF_TX_CTRL = 8'h00;
    localparam logic [7:0] OFF_RX_CTRL = 8'h04;
    localparam logic [7:0] OFF_TX_DATA = 8'h08;
    localparam logic [7:0] OFF_RX_DATA = 8'h0C;
    localparam logic [7:0] OFF_CYC_CNT = 8'h10;
    localparam logic [7:0] OFF_INS_CNT = 8'h14;
    localparam logic [7:0] OFF_CNT_RST = 8'h18;

endpackage

// File: rtl/mips150_mmio_ctrl_if.sv
// X-stage memory bus plus UART byte handshakes seen by the MMIO controller.
interface mips150_mmio_ctrl_if;

    logic [31:0] addr_x;
    logic [3:0]  store_mask_x;
    logic [31:0] store_data_x;
    logic        load_x;
    logic        instr_retire;
    logic [3:0]  store_mask_dmem;
    logic [3:0]  store_mask_imem;
    logic        load_io_sel;
    logic [31:0] io_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        data_out_valid;
    logic        data_in_valid;

    modport master (
        output addr_x, store_mask_x, store_data_x, load_x, instr_retire,
        output tx_ready, rx_data, rx_valid,
        input  store_mask_dmem, store_mask_imem, load_io_sel, io_rdata,
        input  tx_data, tx_valid, rx_ready, data_out_valid, data_in_valid
    );

    modport slave (
        input  addr_x, store_mask_x, store_data_x, load_x, instr_retire,
        input  tx_ready, rx_data, rx_valid,
        output store_mask_dmem, store_mask_imem, load_io_sel, io_rdata,
        output tx_data, tx_valid, rx_ready, data_out_valid, data_in_valid
    );

endinterface

// File: rtl/mips150_mmio_ctrl_rx_fifo.sv
// Synchronous byte FIFO for UART receive; head is visible combinationally.
module mmio_rx_fifo #(
    parameter int RX_DEPTH = 8,
    parameter int RX_AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    logic [7:0]     r_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_wr_ptr;
    logic [RX_AW-1:0] r_rd_ptr;
    logic [RX_AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (RX_AW+1)'(RX_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mips150_mmio_ctrl.sv
// Memory-map decoder, UART TX/RX registers and cycle/instruction counters beside the X stage.
module mips150_mmio_ctrl
    import mips150_mmio_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int RX_AW    = 3
) (
    input logic                 clk,
    input logic                 rst,
    mips150_mmio_ctrl_if.slave  bus
);

    logic [3:0]  w_region;
    logic [7:0]  w_off;
    logic        w_is_io, w_io_store;
    logic        w_tx_hs, w_tx_wr, w_tx_accept, w_tx_drop;
    logic        w_flag_clr, w_cnt_clr;
    logic        w_pop, w_push, w_rx_ready, w_rx_ovf;
    logic        w_full, w_empty;
    logic [7:0]  w_head;
    logic        w_unused_bits;

    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_tx_ovr;
    logic        r_rx_ovf;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ins_cnt;

    assign w_region   = bus.addr_x[31:28];
    assign w_off      = bus.addr_x[7:0];
    assign w_is_io    = (w_region == REGION_IO);
    assign w_io_store = w_is_io && (|bus.store_mask_x);
    assign w_unused_bits = ^{bus.addr_x[27:8], bus.store_data_x[31:8]};

    assign w_tx_hs     = r_tx_valid && bus.tx_ready;
    assign w_tx_wr     = w_io_store && (w_off == OFF_TX_DATA);
    assign w_tx_accept = w_tx_wr && (!r_tx_valid || bus.tx_ready);
    assign w_tx_drop   = w_tx_wr && r_tx_valid && !bus.tx_ready;
    assign w_flag_clr  = w_io_store && (w_off == OFF_TX_CTRL);
    assign w_cnt_clr   = w_io_store && (w_off == OFF_CNT_RST);

    // A same-cycle pop frees a slot, so a full FIFO can still accept a byte.
    assign w_pop      = w_is_io && bus.load_x && (w_off == OFF_RX_DATA) && !w_empty;
    assign w_rx_ready = !w_full || w_pop;
    assign w_push     = bus.rx_valid && w_rx_ready;
    assign w_rx_ovf   = bus.rx_valid && !w_rx_ready;

    mmio_rx_fifo #(.RX_DEPTH(RX_DEPTH), .RX_AW(RX_AW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.rx_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        bus.io_rdata = 32'h0;
        if (w_is_io) begin
            case (w_off)
                OFF_TX_CTRL: bus.io_rdata = {30'h0, r_tx_ovr, !r_tx_valid};
                OFF_RX_CTRL: bus.io_rdata = {30'h0, r_rx_ovf, !w_empty};
                OFF_RX_DATA: bus.io_rdata = w_empty ? 32'h0 : {24'h0, w_head};
                OFF_CYC_CNT: bus.io_rdata = r_cyc_cnt;
                OFF_INS_CNT: bus.io_rdata = r_ins_cnt;
                default:     bus.io_rdata = 32'h0;
            endcase
        end
    end

    // A new overflow event in the same cycle as a clear store leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h0;
            r_tx_ovr   <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_cyc_cnt  <= 32'h0;
            r_ins_cnt  <= 32'h0;
        end else begin
            if (w_tx_accept) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= bus.store_data_x[7:0];
            end else if (w_tx_hs) begin
                r_tx_valid <= 1'b0;
            end
            r_tx_ovr <= w_tx_drop || (r_tx_ovr && !w_flag_clr);
            r_rx_ovf <= w_rx_ovf  || (r_rx_ovf && !w_flag_clr);
            if (w_cnt_clr) begin
                r_cyc_cnt <= 32'h0;
                r_ins_cnt <= 32'h0;
            end else begin
                r_cyc_cnt <= r_cyc_cnt + 32'h1;
                if (bus.instr_retire) r_ins_cnt <= r_ins_cnt + 32'h1;
            end
        end
    end

    always_comb begin
        bus.store_mask_dmem = ((w_region == REGION_DMEM) || (w_region == REGION_BOTH)) ?
                              bus.store_mask_x : 4'h0;
        bus.store_mask_imem = ((w_region == REGION_IMEM) || (w_region == REGION_BOTH)) ?
                              bus.store_mask_x : 4'h0;
    end

    assign bus.load_io_sel    = bus.load_x && w_is_io;
    assign bus.tx_valid       = r_tx_valid;
    assign bus.tx_data        = r_tx_data;
    assign bus.rx_ready       = w_rx_ready;
    assign bus.data_out_valid = !r_tx_valid;
    assign bus.data_in_valid  = !w_empty;

endmodule
